// File: rtl/vga_wishbone_pkg.sv
// rtl/vga_wishbone_pkg.sv - shared timing, address map and framebuffer constants for vga_wishbone
package vga_wishbone_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [13:0] ADDR_CTRL = 14'h2580;
  localparam logic [13:0] ADDR_FG   = 14'h2581;
  localparam logic [13:0] ADDR_IRQ  = 14'h2582;

  localparam int FB_BYTES     = 9600;
  localparam int FB_ROW_BYTES = 40;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic [2:0] bit_sel;
  } pix_stage_t;

  // Each framebuffer pixel covers a 2x2 block of screen pixels, 8 pixels per byte.
  function automatic logic [13:0] fb_index(input logic [9:0] h, input logic [9:0] v);
    fb_index = 14'(32'(v >> 1) * FB_ROW_BYTES + 32'(h >> 4));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - horizontal/vertical counters, raw syncs, visible flag and frame-start strobe
module vga_timing
  import vga_wishbone_pkg::*;
#(
  parameter int H_VISIBLE_P = H_VISIBLE,
  parameter int H_FRONT_P   = H_FRONT,
  parameter int H_SYNC_P    = H_SYNC,
  parameter int H_BACK_P    = H_BACK,
  parameter int V_VISIBLE_P = V_VISIBLE,
  parameter int V_FRONT_P   = V_FRONT,
  parameter int V_SYNC_P    = V_SYNC,
  parameter int V_BACK_P    = V_BACK
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       visible_o,
  output logic       frame_start_o
);

  localparam int HT = H_VISIBLE_P + H_FRONT_P + H_SYNC_P + H_BACK_P;
  localparam int VT = V_VISIBLE_P + V_FRONT_P + V_SYNC_P + V_BACK_P;

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'(HT - 1)) begin
      h_d = '0;
      v_d = (v_q == 10'(VT - 1)) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hsync_o       = !((h_q >= 10'(H_VISIBLE_P + H_FRONT_P)) &&
                           (h_q <  10'(H_VISIBLE_P + H_FRONT_P + H_SYNC_P)));
  assign vsync_o       = !((v_q >= 10'(V_VISIBLE_P + V_FRONT_P)) &&
                           (v_q <  10'(V_VISIBLE_P + V_FRONT_P + V_SYNC_P)));
  assign visible_o     = (h_q < 10'(H_VISIBLE_P)) && (v_q < 10'(V_VISIBLE_P));
  assign frame_start_o = (h_q == '0) && (v_q == 10'(V_VISIBLE_P));

endmodule

// File: rtl/vga_wishbone.sv
// rtl/vga_wishbone.sv - write-only bus slave with 1bpp framebuffer driving 640x480 VGA
module vga_wishbone
  import vga_wishbone_pkg::*;
#(
  parameter int H_VISIBLE_P = H_VISIBLE,
  parameter int H_FRONT_P   = H_FRONT,
  parameter int H_SYNC_P    = H_SYNC,
  parameter int H_BACK_P    = H_BACK,
  parameter int V_VISIBLE_P = V_VISIBLE,
  parameter int V_FRONT_P   = V_FRONT,
  parameter int V_SYNC_P    = V_SYNC,
  parameter int V_BACK_P    = V_BACK
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic        INT_O,
  input  logic        mode,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  logic [9:0]  h, v;
  logic        hsync_raw, vsync_raw, visible, frame_start;
  logic [13:0] adr;
  logic        wr, fb_we, unused_bits;
  logic        ctrl_q, ctrl_d, irq_en_q, irq_en_d;
  logic [11:0] fg_q, fg_d;
  logic [7:0]  fb_mem [FB_BYTES];
  logic [7:0]  fb_rd_q;
  logic [13:0] rd_addr;
  pix_stage_t  s1_q, s1_d;
  logic        hsync_q, vsync_q, int_q, pix;
  logic [11:0] rgb_q, rgb_d;

  vga_timing #(
    .H_VISIBLE_P(H_VISIBLE_P), .H_FRONT_P(H_FRONT_P), .H_SYNC_P(H_SYNC_P), .H_BACK_P(H_BACK_P),
    .V_VISIBLE_P(V_VISIBLE_P), .V_FRONT_P(V_FRONT_P), .V_SYNC_P(V_SYNC_P), .V_BACK_P(V_BACK_P)
  ) u_timing (
    .clk_i(CLK_I), .rst_ni(RST_I), .h_o(h), .v_o(v), .hsync_o(hsync_raw),
    .vsync_o(vsync_raw), .visible_o(visible), .frame_start_o(frame_start)
  );

  assign adr         = ADR_I[13:0];
  assign unused_bits = ^{ADR_I[31:14], DAT_I[31:12]};
  assign wr          = STB_I && WE_I;
  assign fb_we       = wr && (adr < 14'(FB_BYTES));

  always_comb begin
    ctrl_d   = ctrl_q;
    fg_d     = fg_q;
    irq_en_d = irq_en_q;
    if (wr) begin
      case (adr)
        ADDR_CTRL: ctrl_d   = DAT_I[0];
        ADDR_FG:   fg_d     = DAT_I[11:0];
        ADDR_IRQ:  irq_en_d = DAT_I[0];
        default:   ;
      endcase
    end
  end

  // Read port sees the pre-write contents when the bus writes the same byte.
  assign rd_addr = visible ? fb_index(h, v) : '0;

  always_ff @(posedge CLK_I) begin
    if (fb_we) fb_mem[adr] <= DAT_I[7:0];
    fb_rd_q <= fb_mem[rd_addr];
  end

  assign s1_d  = '{hsync: hsync_raw, vsync: vsync_raw, visible: visible, bit_sel: h[3:1]};
  assign pix   = fb_rd_q[3'd7 - s1_q.bit_sel] ^ mode;
  assign rgb_d = (s1_q.visible && ctrl_q && pix) ? fg_q : 12'h000;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ctrl_q   <= 1'b0;
      fg_q     <= 12'hFFF;
      irq_en_q <= 1'b0;
      s1_q     <= '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0, bit_sel: 3'd0};
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= 12'h000;
      int_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      fg_q     <= fg_d;
      irq_en_q <= irq_en_d;
      s1_q     <= s1_d;
      hsync_q  <= s1_q.hsync;
      vsync_q  <= s1_q.vsync;
      rgb_q    <= rgb_d;
      int_q    <= frame_start && irq_en_q;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];
  assign INT_O = int_q;

endmodule

// File: tb/tb_vga_wishbone.sv
// tb/tb_vga_wishbone.sv - scoreboard bench for vga_wishbone with a shortened vertical frame
module tb_vga_wishbone;

  localparam int HT = 800;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic        CLK_I = 1'b0;
  logic        RST_I, STB_I, WE_I, mode;
  logic [31:0] ADR_I, DAT_I;
  logic        INT_O, hsync, vsync;
  logic [3:0]  red, green, blue;

  always #20 CLK_I = ~CLK_I;

  vga_wishbone #(.V_VISIBLE_P(VV), .V_FRONT_P(VF), .V_SYNC_P(VS), .V_BACK_P(VB)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
    .INT_O(INT_O), .mode(mode), .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
  );

  exp_t        sbq[$];
  logic        int_exp;
  logic [7:0]  mem_m [9600];
  logic        ctrl_m, irq_m;
  logic [11:0] fg_m;
  int ch, cv, cyc;
  int n_assert = 0, n_fail = 0;
  int hs_low, hs_fall, vs_low, int_cnt, int_gap, last_int_cyc;
  logic hs_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    ctrl_m = 1'b0;
    fg_m   = 12'hFFF;
    irq_m  = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    logic [7:0] b;
    logic px;
    e.hs  = !(ch >= 656 && ch < 752);
    e.vs  = !(cv >= VV + VF && cv < VV + VF + VS);
    e.rgb = 12'h000;
    if (ch < 640 && cv < VV && ctrl_m) begin
      b  = mem_m[(cv / 2) * 40 + (ch / 2) / 8];
      px = b[7 - ((ch / 2) % 8)] ^ mode;
      if (px) e.rgb = fg_m;
    end
    sbq.push_back(e);
    int_exp = (ch == 0 && cv == VV) && irq_m;
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge CLK_I);
    cyc++;
    ch++;
    if (ch == HT) begin
      ch = 0;
      cv = (cv == VT - 1) ? 0 : cv + 1;
    end
    if (sbq.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = sbq.pop_front();
      n_assert++;
      assert ({hsync, vsync, red, green, blue, INT_O} === {e.hs, e.vs, e.rgb, int_exp}) else begin
        n_fail++;
        $error("FAIL outputs cycle %0d: observed hs=%b vs=%b rgb=%h int=%b expected hs=%b vs=%b rgb=%h int=%b",
               cyc, hsync, vsync, {red, green, blue}, INT_O, e.hs, e.vs, e.rgb, int_exp);
      end
    end
    if (!hsync) hs_low++;
    if (hs_prev && !hsync) hs_fall++;
    hs_prev = hsync;
    if (!vsync) vs_low++;
    if (INT_O) begin
      if (int_cnt > 0) int_gap = cyc - last_int_cyc;
      last_int_cyc = cyc;
      int_cnt++;
    end
    push_expected();
  endtask

  task automatic wait_until(input int h, input int v);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(ch == h && cv == v) && n < 2 * FRAME);
    if (n >= 2 * FRAME) begin
      n_assert++;
      n_fail++;
      $error("FAIL wait_bound: observed timeout expected h=%0d v=%0d", h, v);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    STB_I = 1'b1; WE_I = 1'b1; ADR_I = a; DAT_I = d;
    if (a[13:0] < 14'd9600) mem_m[a[13:0]] = d[7:0];
    else if (a[13:0] == 14'h2580) ctrl_m = d[0];
    else if (a[13:0] == 14'h2581) fg_m = d[11:0];
    else if (a[13:0] == 14'h2582) irq_m = d[0];
    cycle();
    STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic release_reset();
    RST_I = 1'b1;
    ch = 0;
    cv = 0;
    sbq.delete();
    sbq.push_back(exp_t'{hs: 1'b1, vs: 1'b1, rgb: 12'h000});
    push_expected();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'h000);
    check({tag, "_int"}, 32'(INT_O), 32'd0);
  endtask

  initial begin
    RST_I = 1'b1; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0; mode = 1'b0;
    cyc = 0; hs_prev = 1'b1; int_cnt = 0; int_gap = 0; last_int_cyc = 0;
    hs_low = 0; hs_fall = 0; vs_low = 0;
    for (int i = 0; i < 9600; i++) mem_m[i] = 8'h00;
    model_reset();

    #5 RST_I = 1'b0;
    #1 check_reset_outputs("reset_async");
    @(negedge CLK_I);
    @(negedge CLK_I);
    check_reset_outputs("reset_held");
    release_reset();

    for (int i = 0; i < 120; i++) bus_write(32'(i), 32'h0);
    bus_write(32'h0000, 32'h80);
    bus_write(32'd41, 32'h3C);
    bus_write(32'd119, 32'h01);
    bus_write(32'd9599, 32'hAA);
    bus_write(32'h2583, 32'h5A5);
    STB_I = 1'b1; WE_I = 1'b0; ADR_I = 32'h2580; DAT_I = 32'h1;
    cycle();
    STB_I = 1'b0;

    wait_until(0, VV + 1);
    bus_write(32'h2580, 32'h1);
    wait_until(0, 0);
    hs_low = 0; hs_fall = 0; vs_low = 0; int_cnt = 0;
    wait_until(32, 0);
    bus_write(32'd2, 32'hFF);
    wait_until(0, 0);
    check("hsync_low_per_frame", 32'(hs_low), 32'(VT * 96));
    check("hsync_periods_per_frame", 32'(hs_fall), 32'(VT));
    check("vsync_low_per_frame", 32'(vs_low), 32'(VS * HT));

    wait_until(0, VV + 1);
    mode = 1'b1;
    wait_until(0, VV + 1);
    mode = 1'b0;
    bus_write(32'h2581, 32'h0F0);
    bus_write(32'h2580, 32'h0);
    wait_until(0, VV + 1);
    bus_write(32'h2580, 32'h1);
    check("no_irq_before_enable", 32'(int_cnt), 32'd0);
    bus_write(32'h2582, 32'h1);
    wait_until(0, VV);
    wait_until(0, VV);
    bus_write(32'h2582, 32'h0);
    wait_until(0, VV);
    repeat (4) cycle();
    check("irq_pulse_count", 32'(int_cnt), 32'd2);
    check("irq_period", 32'(int_gap), 32'(FRAME));

    wait_until(700, 1);
    #5 RST_I = 1'b0;
    #1 check_reset_outputs("midframe_async");
    model_reset();
    @(negedge CLK_I);
    check_reset_outputs("midframe_held");
    release_reset();
    wait_until(0, VV + 1);
    bus_write(32'h2580, 32'h1);
    wait_until(0, VV + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
